// File: rtl/alu_mult_sequencer.sv
// Shift-and-add 32x32 multiplier (low 32 product bits) that borrows an external
// combinational ALU for every add and shift, one ALU operation per cycle.
module alu_mult_sequencer #(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_shamt,
    input  logic [31:0] alu_result,
    input  logic        alu_zero
);

    localparam logic [3:0] ALU_ADD = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b1110;
    localparam logic [3:0] ALU_SRL = 4'b1100;
    localparam logic [3:0] ALU_AND = 4'b0000;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADD  = 3'd1,
        S_SHL  = 3'd2,
        S_SHR  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] product_q, product_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // State and datapath registers, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            acc_q     <= 32'd0;
            mcand_q   <= 32'd0;
            mplier_q  <= 32'd0;
            count_q   <= 5'd0;
            product_q <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            count_q   <= count_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state, datapath updates and ALU operand steering.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        count_d   = count_q;
        product_d = product_q;
        alu_op    = ALU_AND;
        alu_a     = 32'd0;
        alu_b     = 32'd0;
        alu_shamt = 5'd0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d     = 32'd0;
                    mcand_d   = op_a;
                    mplier_d  = op_b;
                    count_d   = 5'd0;
                    product_d = 32'd0;
                    state_d   = S_ADD;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_ADD: begin
                alu_op = ALU_ADD;
                alu_a  = acc_q;
                alu_b  = mcand_q;
                if (mplier_q[0]) begin
                    acc_d = alu_result;
                end else begin
                    acc_d = acc_q;
                end
                state_d = S_SHL;
            end
            S_SHL: begin
                alu_op    = ALU_SLL;
                alu_b     = mcand_q;
                alu_shamt = 5'd1;
                mcand_d   = alu_result;
                state_d   = S_SHR;
            end
            S_SHR: begin
                alu_op    = ALU_SRL;
                alu_b     = mplier_q;
                alu_shamt = 5'd1;
                mplier_d  = alu_result;
                // acc is final here, so the product is latched on the way into DONE.
                if ((EARLY_EXIT && alu_zero) || (count_q == 5'd31)) begin
                    product_d = acc_q;
                    state_d   = S_DONE;
                end else begin
                    count_d = count_q + 5'd1;
                    state_d = S_ADD;
                end
            end
            S_DONE: begin
                product_d = acc_q;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Runs an early-exit and a fixed-32-iteration instance side by side, each with
// its own ALU model, against a cycle-level reference derived from the arithmetic.
module tb_alu_mult_sequencer;

    localparam logic [3:0] ADD = 4'b0011;
    localparam logic [3:0] SLL = 4'b1110;
    localparam logic [3:0] SRL = 4'b1100;
    localparam logic [3:0] AND = 4'b0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;

    logic        busy_s    [2];
    logic        done_s    [2];
    logic [31:0] prod_s    [2];
    logic [3:0]  alu_op_s  [2];
    logic [31:0] alu_a_s   [2];
    logic [31:0] alu_b_s   [2];
    logic [4:0]  alu_sh_s  [2];
    logic [31:0] alu_res_s [2];
    logic        alu_zero_s[2];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
        case (op)
            ADD:     return a + b;
            SLL:     return b << sh;
            SRL:     return b >> sh;
            AND:     return a & b;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_res_s[0]  = alu_f(alu_op_s[0], alu_a_s[0], alu_b_s[0], alu_sh_s[0]);
    assign alu_zero_s[0] = (alu_res_s[0] == 32'd0);
    assign alu_res_s[1]  = alu_f(alu_op_s[1], alu_a_s[1], alu_b_s[1], alu_sh_s[1]);
    assign alu_zero_s[1] = (alu_res_s[1] == 32'd0);

    alu_mult_sequencer #(.EARLY_EXIT(1'b1)) u_ee1 (
        .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy_s[0]), .done(done_s[0]), .product(prod_s[0]),
        .alu_op(alu_op_s[0]), .alu_a(alu_a_s[0]), .alu_b(alu_b_s[0]),
        .alu_shamt(alu_sh_s[0]), .alu_result(alu_res_s[0]), .alu_zero(alu_zero_s[0])
    );

    alu_mult_sequencer #(.EARLY_EXIT(1'b0)) u_ee0 (
        .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy_s[1]), .done(done_s[1]), .product(prod_s[1]),
        .alu_op(alu_op_s[1]), .alu_a(alu_a_s[1]), .alu_b(alu_b_s[1]),
        .alu_shamt(alu_sh_s[1]), .alu_result(alu_res_s[1]), .alu_zero(alu_zero_s[1])
    );

    // Iterations: one per significant multiplier bit (at least one) with early exit, else 32.
    function automatic int niter(input logic [31:0] b, input bit ee);
        int r;
        r = 1;
        if (!ee) begin
            r = 32;
        end else begin
            for (int j = 0; j < 32; j++) begin
                if (b[j]) r = j + 1;
            end
        end
        return r;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b1; op_a = $urandom; op_b = $urandom;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (busy_s[d] !== 1'b0 || done_s[d] !== 1'b0) begin
                $display("FAIL reset_flags dut%0d busy=%0b done=%0b want 0/0", d, busy_s[d], done_s[d]);
            end else n_pass++;
            n_checks++;
            if (prod_s[d] !== 32'd0) begin
                $display("FAIL reset_product dut%0d got %h want 0", d, prod_s[d]);
            end else n_pass++;
            n_checks++;
            if ({alu_op_s[d], alu_a_s[d], alu_b_s[d], alu_sh_s[d]} !== {AND, 32'd0, 32'd0, 5'd0}) begin
                $display("FAIL reset_alu dut%0d op=%h a=%h b=%h sh=%0d want AND/0/0/0",
                         d, alu_op_s[d], alu_a_s[d], alu_b_s[d], alu_sh_s[d]);
            end else n_pass++;
        end
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (busy_s[d] !== 1'b0) begin
                $display("FAIL reset_release_idle dut%0d busy=%0b want 0", d, busy_s[d]);
            end else n_pass++;
        end
    endtask

    // One operation observed for 100 cycles; optional ignored start pulse and mid-run reset.
    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input int ign_k, input int rst_k);
        int n [2];
        int lat, i, ph;
        bit act, ab;
        logic [31:0] ep, msk, e_a, e_b, e_p;
        logic [3:0]  e_op;
        logic [4:0]  e_sh;
        logic        e_busy, e_done;
        ep   = a * b;
        n[0] = niter(b, 1'b1);
        n[1] = niter(b, 1'b0);
        ab   = (rst_k > 0);
        @(negedge clk);
        start = 1'b1; op_a = a; op_b = b;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                lat = 3 * n[d] + 1;
                act = (k <= 3 * n[d]) && (!ab || k <= rst_k);
                i   = (k - 1) / 3;
                ph  = (k - 1) % 3;
                msk = (32'd1 << i) - 32'd1;
                e_op   = !act ? AND : (ph == 0) ? ADD : (ph == 1) ? SLL : SRL;
                e_a    = (act && ph == 0) ? a * (b & msk) : 32'd0;
                e_b    = !act ? 32'd0 : (ph == 2) ? (b >> i) : (a << i);
                e_sh   = (act && ph != 0) ? 5'd1 : 5'd0;
                e_busy = ab ? (k <= rst_k && k <= lat) : (k <= lat);
                e_done = !ab && (k == lat);
                e_p    = (!ab && k >= lat) ? ep : 32'd0;
                n_checks++;
                if (busy_s[d] !== e_busy) begin
                    $display("FAIL %s busy dut%0d k=%0d got %0b want %0b", name, d, k, busy_s[d], e_busy);
                end else n_pass++;
                n_checks++;
                if (done_s[d] !== e_done) begin
                    $display("FAIL %s done dut%0d k=%0d got %0b want %0b", name, d, k, done_s[d], e_done);
                end else n_pass++;
                n_checks++;
                if (prod_s[d] !== e_p) begin
                    $display("FAIL %s product dut%0d k=%0d got %h want %h", name, d, k, prod_s[d], e_p);
                end else n_pass++;
                n_checks++;
                if (alu_op_s[d] !== e_op) begin
                    $display("FAIL %s alu_op dut%0d k=%0d got %h want %h", name, d, k, alu_op_s[d], e_op);
                end else n_pass++;
                n_checks++;
                if ({alu_a_s[d], alu_b_s[d], alu_sh_s[d]} !== {e_a, e_b, e_sh}) begin
                    $display("FAIL %s alu_operands dut%0d k=%0d got %h/%h/%0d want %h/%h/%0d", name, d, k,
                             alu_a_s[d], alu_b_s[d], alu_sh_s[d], e_a, e_b, e_sh);
                end else n_pass++;
            end
            if (k == 1) start = 1'b0;
            if (ign_k > 0 && k == ign_k) begin
                start = 1'b1; op_a = $urandom; op_b = $urandom;
            end
            if (ign_k > 0 && k == ign_k + 1) start = 1'b0;
            if (ab && k == rst_k) reset = 1'b1;
            if (ab && k == rst_k + 1) reset = 1'b0;
        end
    endtask

    task automatic test_directed();
        run_op("3x5", 32'd3, 32'd5, 0, 0);
        run_op("7x0", 32'd7, 32'd0, 0, 0);
        run_op("ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run_op("msb_only", 32'h1234_5679, 32'h8000_0000, 0, 0);
        run_op("x1", 32'hDEAD_BEEF, 32'd1, 0, 0);
    endtask

    task automatic test_ignore_and_reset();
        run_op("3x5_ignore_start", 32'd3, 32'd5, 5, 0);
        run_op("3x5_reset_mid", 32'd3, 32'd5, 0, 6);
        run_op("after_reset", 32'd9, 32'd11, 0, 0);
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int r = 0; r < 8; r++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            run_op("random", a, b, 0, 0);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, ep, e_p;
        int n [2];
        int p, j, dcnt [2], ecnt [2], waited;
        logic e_busy, e_done;
        a = $urandom; b = 32'd5 + ($urandom & 32'd2);
        ep = a * b;
        n[0] = niter(b, 1'b1);
        n[1] = niter(b, 1'b0);
        dcnt[0] = 0; dcnt[1] = 0; ecnt[0] = 0; ecnt[1] = 0;
        @(negedge clk);
        start = 1'b1; op_a = a; op_b = b;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                p = 3 * n[d] + 2;
                j = (k - 1) % p + 1;
                e_done = (j == 3 * n[d] + 1);
                e_busy = (j != p);
                e_p    = (j >= 3 * n[d] + 1) ? ep : 32'd0;
                if (e_done) ecnt[d]++;
                if (done_s[d] === 1'b1) dcnt[d]++;
                n_checks++;
                if (busy_s[d] !== e_busy || done_s[d] !== e_done) begin
                    $display("FAIL b2b_flags dut%0d k=%0d busy/done got %0b/%0b want %0b/%0b",
                             d, k, busy_s[d], done_s[d], e_busy, e_done);
                end else n_pass++;
                n_checks++;
                if (prod_s[d] !== e_p) begin
                    $display("FAIL b2b_product dut%0d k=%0d got %h want %h", d, k, prod_s[d], e_p);
                end else n_pass++;
            end
        end
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (dcnt[d] !== ecnt[d]) begin
                $display("FAIL b2b_done_count dut%0d got %0d want %0d", d, dcnt[d], ecnt[d]);
            end else n_pass++;
        end
        start = 1'b0;
        waited = 0;
        while ((busy_s[0] !== 1'b0 || busy_s[1] !== 1'b0) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (busy_s[0] !== 1'b0 || busy_s[1] !== 1'b0) begin
            $display("FAIL b2b_drain busy got %0b/%0b want 0/0 within 200 cycles", busy_s[0], busy_s[1]);
        end else n_pass++;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; op_a = 32'd0; op_b = 32'd0;
        test_reset();
        test_directed();
        test_ignore_and_reset();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_mult_sequencer.md
ALU_MULT_SEQUENCER -- requirements
Module: alu_mult_sequencer

Interface
REQ-001 SHALL have parameter: EARLY_EXIT, 1, when 1 terminate once remaining multiplier is zero; when 0 always run 32 iterations.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request a multiply; sampled only in IDLE.
REQ-005 SHALL have port: op_a  input  32  multiplicand, captured on accepted start.
REQ-006 SHALL have port: op_b  input  32  multiplier, captured on accepted start.
REQ-007 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-008 SHALL have port: done  output  1  one-cycle pulse when product is valid.
REQ-009 SHALL have port: product  output  32  low 32 bits of op_a*op_b, held until next accepted start.
REQ-010 SHALL have port: alu_op  output  4  ALUOperation to shared ALU.
REQ-011 SHALL have ports: alu_a, alu_b  output  32 each  ALU A and B operands.
REQ-012 SHALL have port: alu_shamt  output  5  ALU shift amount.
REQ-013 SHALL have ports: alu_result  input  32, alu_zero  input  1  ALU combinational outputs, same cycle.

Function
REQ-014 SHALL use ALU encodings ADD=4'b0011, SLL=4'b1110, SRL=4'b1100, AND=4'b0000.
REQ-015 SHALL hold internal registers acc, mcand, mplier (32b) and iter count (5b).
REQ-016 SHALL implement states IDLE, ADD, SHL, SHR, DONE.
REQ-017 IDLE: start=1 -> acc=0, mcand=op_a, mplier=op_b, count=0, product cleared to 0, next ADD; start=0 -> stay.
REQ-018 ADD: drive alu_op=ADD, alu_a=acc, alu_b=mcand; capture alu_result into acc only if mplier[0]=1; next SHL.
REQ-019 SHL: drive alu_op=SLL, alu_b=mcand, alu_shamt=1; capture alu_result into mcand; next SHR.
REQ-020 SHR: drive alu_op=SRL, alu_b=mplier, alu_shamt=1; capture alu_result into mplier.
REQ-021 SHR exit: (EARLY_EXIT=1 and alu_zero=1) or count=31 -> DONE; else count+1, next ADD.
REQ-022 DONE: product=acc, done=1 for exactly this cycle, next IDLE; start in DONE ignored.
REQ-023 IDLE/DONE SHALL drive alu_op=AND, alu_a=0, alu_b=0, alu_shamt=0; unused operands in ADD/SHL/SHR driven 0.
REQ-024 Latency: start accepted at edge T -> ADD in cycle T+1; N iterations occupy 3N cycles; done high in cycle T+3N+1; N in 1..32.
REQ-025 Arithmetic SHALL wrap modulo 2^32; overflow ignored, no flag.
REQ-026 start, op_a, op_b changes while busy SHALL have no effect.
REQ-027 done and busy SHALL never be high in IDLE; busy high in DONE.

Reset
REQ-028 reset=1 at any edge SHALL force IDLE, busy=0, done=0, product=0, acc/mcand/mplier/count=0, overriding start.
REQ-029 reset mid-operation SHALL abort with no done pulse; next start after reset deasserts SHALL run normally.

Verification
REQ-030 op_a=3, op_b=5, EARLY_EXIT=1 -> 3 iterations, done in cycle T+10, product=15.
REQ-031 op_a=7, op_b=0 -> 1 iteration, done in cycle T+4, product=0; acc never updated.
REQ-032 op_a=op_b=32'hFFFFFFFF -> 32 iterations, done in cycle T+97, product=32'h00000001.
REQ-033 EARLY_EXIT=0, op_a=3, op_b=5 -> done in cycle T+97, product=15; alu_op sequence ADD,SLL,SRL repeated 32 times.
REQ-034 start pulsed with different operands at T+5 of 3*5 run -> ignored, product=15; reset at T+6 of second run -> IDLE next cycle, no done, product=0.
REQ-035 Back-to-back: start held high continuously -> new operation accepted in the IDLE cycle after each DONE, one done pulse per operation.
